// File: rtl/number_analyzer_ctrl.sv
// Sequencing controller for the number-analysis datapath.
// Accepts an operand, holds the Fibonacci checker in reset for RST_CYCLES,
// runs it until done or timeout, then presents the captured results.
module number_analyzer_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             chk_rst,
  output logic [WIDTH-1:0] chk_a,
  input  logic             chk_done,
  input  logic             chk_fibo,
  input  logic             chk_pal,
  input  logic             chk_odd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_fibo,
  output logic             out_pal,
  output logic             out_odd,
  output logic             out_timeout,
  output logic             busy,
  output logic [15:0]      count
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, HOLD} state_t;

  localparam logic [7:0]  RST_LOAD  = 8'(RST_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  rst_cnt;
  logic [15:0] wait_cnt;
  logic        run_end;

  assign run_end   = chk_done || (wait_cnt == WAIT_LAST);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CLEAR;
      CLEAR:   if (rst_cnt == '0) state_next = RUN;
      RUN:     if (run_end) state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Operand latch, counters, result capture and completion count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chk_rst     <= 1'b1;
      chk_a       <= '0;
      rst_cnt     <= '0;
      wait_cnt    <= '0;
      out_data    <= '0;
      out_fibo    <= 1'b0;
      out_pal     <= 1'b0;
      out_odd     <= 1'b0;
      out_timeout <= 1'b0;
      count       <= '0;
    end else begin
      // Registered from next state so the checker sees reset drop exactly on RUN entry.
      chk_rst <= (state_next != RUN);
      case (state)
        IDLE: begin
          if (in_valid) begin
            chk_a   <= in_data;
            rst_cnt <= RST_LOAD;
          end
        end
        CLEAR: begin
          if (rst_cnt == '0) wait_cnt <= '0;
          else               rst_cnt  <= rst_cnt - 8'd1;
        end
        RUN: begin
          wait_cnt <= wait_cnt + 16'd1;
          if (run_end) begin
            // Done takes priority over a coincident timeout.
            out_data    <= chk_a;
            out_fibo    <= chk_done & chk_fibo;
            out_pal     <= chk_pal;
            out_odd     <= chk_odd;
            out_timeout <= ~chk_done;
          end
        end
        HOLD: begin
          if (out_ready) count <= count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_number_analyzer_ctrl.sv
// Directed and randomized checks of number_analyzer_ctrl against a
// behavioural model of the checkers and of the expected result timing.
module tb_number_analyzer_ctrl;

  localparam int RST = 2;
  localparam int TMO = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        chk_rst;
  logic [31:0] chk_a;
  logic        chk_done;
  logic        chk_fibo;
  logic        chk_pal;
  logic        chk_odd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_fibo;
  logic        out_pal;
  logic        out_odd;
  logic        out_timeout;
  logic        busy;
  logic [15:0] count;

  int vectors   = 0;
  int errors    = 0;
  int exp_count = 0;
  int done_delay = 0;     // 0 = checker never finishes
  logic done_pulse = 1'b0;
  int run_cnt = 0;

  number_analyzer_ctrl #(.WIDTH(32), .RST_CYCLES(RST), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .chk_rst(chk_rst), .chk_a(chk_a), .chk_done(chk_done),
    .chk_fibo(chk_fibo), .chk_pal(chk_pal), .chk_odd(chk_odd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_fibo(out_fibo), .out_pal(out_pal), .out_odd(out_odd),
    .out_timeout(out_timeout), .busy(busy), .count(count)
  );

  always #5 clock = ~clock;

  function automatic logic is_fib(input logic [31:0] x);
    longint a = 0;
    longint b = 1;
    longint t;
    while (a < longint'(x)) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a == longint'(x);
  endfunction

  function automatic logic is_pal(input logic [31:0] x);
    for (int i = 0; i < 16; i++)
      if (x[i] != x[31-i]) return 1'b0;
    return 1'b1;
  endfunction

  // Checker models: combinational palindrome/odd, Fibonacci with run-time latency.
  assign chk_fibo = is_fib(chk_a);
  assign chk_pal  = is_pal(chk_a);
  assign chk_odd  = chk_a[0];
  assign chk_done = done_pulse ||
                    (!chk_rst && done_delay != 0 && run_cnt >= done_delay - 1);

  always @(posedge clock) begin
    if (chk_rst) run_cnt <= 0;
    else         run_cnt <= run_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, clear/run timing, result, backpressure, handoff.
  task automatic run_op(input logic [31:0] d, input int dly, input int hold, input bit pulse_clear);
    bit tmo;
    int lat;
    tmo = (dly == 0) || (dly > TMO);
    lat = RST + (tmo ? TMO : dly);
    @(negedge clock);
    check("in_ready_idle", in_ready, 1);
    in_valid   = 1'b1;
    in_data    = d;
    done_delay = dly;
    @(negedge clock);
    in_valid = 1'b0;
    in_data  = $urandom;
    check("chk_a", chk_a, d);
    check("busy_run", busy, 1);
    for (int n = 0; n <= lat; n++) begin
      if (n > 0) @(negedge clock);
      check("out_valid_timing", out_valid, n == lat);
      check("chk_rst_timing", chk_rst, (n < RST) || (n == lat));
      done_pulse = pulse_clear && (n == 0);
    end
    check("out_data", out_data, d);
    check("out_fibo", out_fibo, !tmo && is_fib(d));
    check("out_pal", out_pal, is_pal(d));
    check("out_odd", out_odd, (d % 2) == 1);
    check("out_timeout", out_timeout, tmo);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, d);
      check("bp_fibo", out_fibo, !tmo && is_fib(d));
      check("bp_in_ready", in_ready, 0);
      check("bp_busy", busy, 1);
      check("bp_count", count, exp_count);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    exp_count = (exp_count + 1) % 65536;
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_busy", busy, 0);
    check("post_count", count, exp_count);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_state_ready", in_ready, 1);
    check("rst_chk_rst", chk_rst, 1);
    check("rst_chk_a", chk_a, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;

    // Directed transactions.
    run_op(32'd317811, 5, 0, 1'b0);
    run_op(32'd999610691, 3, 1, 1'b0);
    run_op(32'd0, 1, 0, 1'b0);
    run_op(32'd55, 0, 0, 1'b0);              // never done -> timeout
    run_op(32'd2971215073, 7, 10, 1'b0);     // backpressure
    run_op(32'd144, TMO, 0, 1'b1);           // done on timeout edge, CLEAR pulse
    run_op(32'd144, TMO + 1, 0, 1'b0);       // done one cycle too late

    // Reset mid-RUN.
    @(negedge clock);
    in_valid   = 1'b1;
    in_data    = 32'd89;
    done_delay = 10;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (RST + 3) @(negedge clock);
    check("midrun_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("arst_chk_rst", chk_rst, 1);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_count", count, 0);
    check("arst_chk_a", chk_a, 0);
    check("arst_out_data", out_data, 0);
    check("arst_out_timeout", out_timeout, 0);
    exp_count = 0;
    @(negedge clock);
    reset = 1'b1;
    run_op(32'd89, 4, 0, 1'b0);

    // Randomized transactions.
    for (int k = 0; k < 12; k++) begin
      logic [31:0] d;
      int dly;
      d   = (k % 3 == 0) ? 32'd6765 : $urandom;
      dly = $urandom_range(0, TMO + 3);
      run_op(d, dly, $urandom_range(0, 3), 1'(k % 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
